alu_64bit_issue: RTL and testbench

ALU_64BIT_ISSUE -- requirements
Module: alu_64bit_issue

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_64bit_core.sv | 29 ++
 rtl/alu_64bit_issue.sv | 111 +++++++++++
 tb/tb_alu_64bit_issue.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the 64-bit ALU issue block: data width and opcode encoding.
package alu_pkg;
  localparam int DATA_W = 64;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_RSUB = 3'b010,
    OP_OR   = 3'b011,
    OP_AND  = 3'b100,
    OP_XOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_ILL  = 3'b111
  } alu_op_e;
endpackage

// File: rtl/alu_64bit_core.sv
// Purely combinational 64-bit ALU datapath; carry-out is dropped (modulo 2^64).
module alu_64bit_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        oper,
  output logic [DATA_W-1:0] sum,
  output logic              illegal
);

  // Opcode decode and result selection
  always_comb begin
    sum     = {DATA_W{1'b0}};
    illegal = 1'b0;
    case (alu_op_e'(oper))
      OP_ADD:  sum = a + b;
      OP_SUB:  sum = a - b;
      OP_RSUB: sum = b - a;
      OP_OR:   sum = a | b;
      OP_AND:  sum = a & b;
      OP_XOR:  sum = a ^ b;
      OP_XNOR: sum = ~(a ^ b);
      OP_ILL:  illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_64bit_issue.sv
// Command FIFO feeding a single ALU core, with a registered response stage
// and a count of completed response handshakes.
module alu_64bit_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_oper,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_sum,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_illegal,
  output logic [15:0]       rsp_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [DATA_W-1:0] a_mem_r   [DEPTH];
  logic [DATA_W-1:0] b_mem_r   [DEPTH];
  logic [2:0]        op_mem_r  [DEPTH];
  logic [TAG_W-1:0]  tag_mem_r [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              load_s;
  logic              rsp_fire_s;
  logic [DATA_W-1:0] core_sum_s;
  logic              core_illegal_s;

  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_sum_r;
  logic [TAG_W-1:0]  rsp_tag_r;
  logic              rsp_illegal_r;
  logic [15:0]       rsp_count_r;

  // Same index with differing wrap bit means the FIFO is full
  assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign push_s     = cmd_valid && !full_s;
  assign load_s     = !empty_s && (!rsp_valid_r || rsp_ready);
  assign rsp_fire_s = rsp_valid_r && rsp_ready;

  alu_64bit_core u_core (
    .a       (a_mem_r[rd_ptr_r[AW-1:0]]),
    .b       (b_mem_r[rd_ptr_r[AW-1:0]]),
    .oper    (op_mem_r[rd_ptr_r[AW-1:0]]),
    .sum     (core_sum_s),
    .illegal (core_illegal_s)
  );

  // FIFO storage write; entries are qualified by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      a_mem_r[wr_ptr_r[AW-1:0]]   <= cmd_a;
      b_mem_r[wr_ptr_r[AW-1:0]]   <= cmd_b;
      op_mem_r[wr_ptr_r[AW-1:0]]  <= cmd_oper;
      tag_mem_r[wr_ptr_r[AW-1:0]] <= cmd_tag;
    end
  end

  // FIFO pointers, response register and handshake counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_sum_r     <= {DATA_W{1'b0}};
      rsp_tag_r     <= {TAG_W{1'b0}};
      rsp_illegal_r <= 1'b0;
      rsp_count_r   <= 16'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (load_s) begin
        rd_ptr_r      <= rd_ptr_r + PTR_W'(1);
        rsp_valid_r   <= 1'b1;
        rsp_sum_r     <= core_sum_s;
        rsp_tag_r     <= tag_mem_r[rd_ptr_r[AW-1:0]];
        rsp_illegal_r <= core_illegal_s;
      end else if (rsp_fire_s) begin
        rsp_valid_r <= 1'b0;
      end
      if (rsp_fire_s) begin
        rsp_count_r <= rsp_count_r + 16'd1;
      end
    end
  end

  assign cmd_ready   = !full_s;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_sum     = rsp_sum_r;
  assign rsp_tag     = rsp_tag_r;
  assign rsp_illegal = rsp_illegal_r;
  assign rsp_count   = rsp_count_r;

endmodule

// File: tb/tb_alu_64bit_issue.sv
// Directed and randomized self-checking bench for alu_64bit_issue.
module tb_alu_64bit_issue;
  import alu_pkg::*;

  localparam int TAG_W = 4;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_oper;
  logic [63:0]       cmd_a;
  logic [63:0]       cmd_b;
  logic [TAG_W-1:0]  cmd_tag;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_sum;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_illegal;
  logic [15:0]       rsp_count;

  int errors    = 0;
  int checks    = 0;
  int exp_count = 0;

  typedef struct packed {
    logic [63:0]      s;
    logic [TAG_W-1:0] t;
    logic             il;
  } exp_t;

  exp_t q[$];

  alu_64bit_issue #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_oper    (cmd_oper),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_tag     (cmd_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_sum     (rsp_sum),
    .rsp_tag     (rsp_tag),
    .rsp_illegal (rsp_illegal),
    .rsp_count   (rsp_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU written with two's-complement negation rather than '-'
  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a + (~b) + 64'd1;
      3'd2:    return b + (~a) + 64'd1;
      3'd3:    return a | b;
      3'd4:    return a & b;
      3'd5:    return a ^ b;
      3'd6:    return a ^ ~b;
      default: return 64'd0;
    endcase
  endfunction

  task automatic run_one(input string name, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [3:0] tag,
                         input logic [63:0] exp_sum, input logic exp_ill);
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_oper  = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk({name, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({name, "_sum"}, rsp_sum, exp_sum);
    chk({name, "_tag"}, 64'(rsp_tag), 64'(tag));
    chk({name, "_illegal"}, 64'(rsp_illegal), 64'(exp_ill));
    tick();
    exp_count++;
    chk({name, "_count"}, 64'(rsp_count), 64'(exp_count));
  endtask

  initial begin
    int acc;
    int n_sent;
    int n_recv;
    logic stale;
    logic do_acc;
    logic do_con;
    exp_t e;

    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_oper  = 3'd0;
    cmd_a     = 64'd0;
    cmd_b     = 64'd0;
    cmd_tag   = 4'd0;
    rsp_ready = 1'b0;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_sum", rsp_sum, 64'd0);
    chk("rst_tag", 64'(rsp_tag), 64'd0);
    chk("rst_illegal", 64'(rsp_illegal), 64'd0);
    chk("rst_count", 64'(rsp_count), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    #7 rst_n = 1'b1;

    // ADD latency: accepted at edge N, valid after edge N+1
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_oper  = 3'b000;
    cmd_a     = 64'd5;
    cmd_b     = 64'd7;
    cmd_tag   = 4'd3;
    tick();
    cmd_valid = 1'b0;
    chk("add_lat_n", 64'(rsp_valid), 64'd0);
    tick();
    chk("add_lat_n1", 64'(rsp_valid), 64'd1);
    chk("add_sum", rsp_sum, 64'd12);
    chk("add_tag", 64'(rsp_tag), 64'd3);
    tick();
    exp_count++;
    chk("add_count", 64'(rsp_count), 64'(exp_count));
    chk("add_drained", 64'(rsp_valid), 64'd0);

    run_one("sub",  3'b001, 64'd3, 64'd5, 4'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_one("rsub", 3'b010, 64'd3, 64'd5, 4'd2, 64'd2, 1'b0);
    run_one("addw", 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd4, 64'd0, 1'b0);
    run_one("or",   3'b011, 64'h0000_0000_0000_F0F0, 64'h0000_0000_0000_0FF0, 4'd5, 64'h0000_0000_0000_FFF0, 1'b0);
    run_one("and",  3'b100, 64'h0000_0000_0000_F0F0, 64'h0000_0000_0000_0FF0, 4'd6, 64'h0000_0000_0000_00F0, 1'b0);
    run_one("xor",  3'b101, 64'h0000_0000_0000_F0F0, 64'h0000_0000_0000_0FF0, 4'd7, 64'h0000_0000_0000_FF00, 1'b0);
    run_one("xnor", 3'b110, 64'h0000_0000_0000_F0F0, 64'h0000_0000_0000_0FF0, 4'd8, 64'hFFFF_FFFF_FFFF_00FF, 1'b0);
    run_one("ill",  3'b111, 64'hFF, 64'hFF, 4'd9, 64'd0, 1'b1);

    // Backpressure: capacity is DEPTH+1 = 5
    rsp_ready = 1'b0;
    acc = 0;
    for (int t = 0; t < 10; t++) begin
      cmd_valid = 1'b1;
      cmd_oper  = 3'b000;
      cmd_a     = 64'(t);
      cmd_b     = 64'd0;
      cmd_tag   = 4'(t);
      if (cmd_ready) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd5);
    chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("bp_hold_tag", 64'(rsp_tag), 64'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_tag", 64'(rsp_tag), 64'(i));
      chk("bp_sum", rsp_sum, 64'(i));
      tick();
    end
    exp_count += 5;
    chk("bp_count", 64'(rsp_count), 64'(exp_count));
    chk("bp_drained", 64'(rsp_valid), 64'd0);

    // Reset with three commands in flight
    rsp_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cmd_valid = 1'b1;
      cmd_oper  = 3'b000;
      cmd_a     = 64'(i);
      cmd_b     = 64'd0;
      cmd_tag   = 4'(i);
      tick();
    end
    cmd_valid = 1'b0;
    chk("mid_pre_valid", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_count", 64'(rsp_count), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    #2 rst_n = 1'b1;
    exp_count = 0;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_oper  = 3'b000;
    cmd_a     = 64'd1;
    cmd_b     = 64'd1;
    cmd_tag   = 4'd9;
    tick();
    cmd_valid = 1'b0;
    chk("post_rst_n", 64'(rsp_valid), 64'd0);
    tick();
    chk("post_rst_valid", 64'(rsp_valid), 64'd1);
    chk("post_rst_tag", 64'(rsp_tag), 64'd9);
    chk("post_rst_sum", rsp_sum, 64'd2);
    tick();
    exp_count++;
    chk("post_rst_count", 64'(rsp_count), 64'(exp_count));
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) stale = 1'b1;
      tick();
    end
    chk("no_stale", 64'(stale), 64'd0);

    // Streaming with random backpressure against the model
    n_sent = 0;
    n_recv = 0;
    for (int cyc = 0; cyc < 3000 && n_recv < 100; cyc++) begin
      if (n_sent < 100) begin
        cmd_valid = 1'b1;
        cmd_oper  = 3'($urandom_range(0, 7));
        cmd_a     = {$urandom, $urandom};
        cmd_b     = {$urandom, $urandom};
        cmd_tag   = n_sent[3:0];
      end else begin
        cmd_valid = 1'b0;
      end
      rsp_ready = 1'($urandom_range(0, 1));
      do_acc = cmd_valid && cmd_ready;
      do_con = rsp_valid && rsp_ready;
      if (do_con) begin
        chk("stm_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("stm_sum", rsp_sum, e.s);
          chk("stm_tag", 64'(rsp_tag), 64'(e.t));
          chk("stm_illegal", 64'(rsp_illegal), 64'(e.il));
          n_recv++;
          exp_count++;
        end
      end
      if (do_acc) begin
        e.s  = model(cmd_oper, cmd_a, cmd_b);
        e.t  = cmd_tag;
        e.il = (cmd_oper == 3'b111);
        q.push_back(e);
        n_sent++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("stm_recv", 64'(n_recv), 64'd100);
    chk("stm_leftover", 64'(q.size()), 64'd0);
    chk("stm_count", 64'(rsp_count), 64'(exp_count));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
